// File: rtl/fd_dx_pipe_ctrl.sv
// F/D and D/X pipeline latches with load-use, multdiv and branch-flush control.
// Provides a PC write enable, inserts NOP bubbles, and keeps saturating stall/flush counters.
module fd_dx_pipe_ctrl #(
  parameter int          CNT_W = 16,
  parameter logic [31:0] NOP   = 32'h0000_0000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_insn,
  input  logic             load_use_hzd,
  input  logic             flush,
  input  logic             md_ready,
  output logic             pc_en,
  output logic [31:0]      fd_pc,
  output logic [31:0]      fd_insn,
  output logic             fd_valid,
  output logic [31:0]      dx_pc,
  output logic [31:0]      dx_insn,
  output logic             dx_valid,
  output logic             md_start,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] md_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             dbg_state
);

  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_fd_pc, r_fd_insn, r_dx_pc, r_dx_insn;
  logic             r_fd_valid, r_dx_valid;
  logic [CNT_W-1:0] r_lu_cnt, r_md_cnt, r_fl_cnt;

  logic w_dx_md, w_hzd;
  logic w_pc_en, w_md_start;
  logic w_fd_load, w_fd_clear, w_dx_load, w_dx_bubble;
  logic w_lu_inc, w_md_inc, w_fl_inc;

  assign w_dx_md = r_dx_valid && (r_dx_insn[31:27] == 5'b00000) &&
                   ((r_dx_insn[6:2] == 5'b00110) || (r_dx_insn[6:2] == 5'b00111));
  assign w_hzd   = load_use_hzd && r_fd_valid && r_dx_valid;

  // Multdiv handshake: md_start is a single-cycle request issued from RUN when a
  // mul/div sits in DX; md_ready is the completion strobe and only matters in MD_WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_en     = 1'b0;
    w_md_start  = 1'b0;
    w_fd_load   = 1'b0;
    w_fd_clear  = 1'b0;
    w_dx_load   = 1'b0;
    w_dx_bubble = 1'b0;
    w_lu_inc    = 1'b0;
    w_md_inc    = 1'b0;
    w_fl_inc    = 1'b0;
    case (r_state)
      RUN: begin
        if (flush) begin
          w_pc_en     = 1'b1;
          w_fd_clear  = 1'b1;
          w_dx_bubble = 1'b1;
          w_fl_inc    = 1'b1;
        end else if (w_dx_md) begin
          w_md_start  = 1'b1;
          w_md_inc    = 1'b1;
          w_state_nxt = MD_WAIT;
        end else if (w_hzd) begin
          w_dx_bubble = 1'b1;
          w_lu_inc    = 1'b1;
        end else begin
          w_pc_en   = 1'b1;
          w_fd_load = 1'b1;
          w_dx_load = 1'b1;
        end
      end
      MD_WAIT: begin
        if (!md_ready) begin
          w_md_inc = 1'b1;
        end else begin
          w_state_nxt = RUN;
          if (w_hzd) begin
            w_dx_bubble = 1'b1;
            w_lu_inc    = 1'b1;
          end else begin
            w_pc_en   = 1'b1;
            w_fd_load = 1'b1;
            w_dx_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RUN;
      r_fd_pc    <= 32'h0;
      r_fd_insn  <= NOP;
      r_fd_valid <= 1'b0;
      r_dx_pc    <= 32'h0;
      r_dx_insn  <= NOP;
      r_dx_valid <= 1'b0;
      r_lu_cnt   <= '0;
      r_md_cnt   <= '0;
      r_fl_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fd_clear) begin
        r_fd_pc    <= 32'h0;
        r_fd_insn  <= NOP;
        r_fd_valid <= 1'b0;
      end else if (w_fd_load) begin
        r_fd_pc    <= if_pc;
        r_fd_insn  <= if_insn;
        r_fd_valid <= 1'b1;
      end
      if (w_dx_bubble) begin
        r_dx_pc    <= 32'h0;
        r_dx_insn  <= NOP;
        r_dx_valid <= 1'b0;
      end else if (w_dx_load) begin
        r_dx_pc    <= r_fd_pc;
        r_dx_insn  <= r_fd_insn;
        r_dx_valid <= r_fd_valid;
      end
      if (w_lu_inc && (r_lu_cnt != '1)) r_lu_cnt <= r_lu_cnt + CNT_ONE;
      if (w_md_inc && (r_md_cnt != '1)) r_md_cnt <= r_md_cnt + CNT_ONE;
      if (w_fl_inc && (r_fl_cnt != '1)) r_fl_cnt <= r_fl_cnt + CNT_ONE;
    end
  end

  // The combinational strobes must stay quiet while reset is held.
  assign pc_en        = w_pc_en && reset_n;
  assign md_start     = w_md_start && reset_n;
  assign fd_pc        = r_fd_pc;
  assign fd_insn      = r_fd_insn;
  assign fd_valid     = r_fd_valid;
  assign dx_pc        = r_dx_pc;
  assign dx_insn      = r_dx_insn;
  assign dx_valid     = r_dx_valid;
  assign lu_stall_cnt = r_lu_cnt;
  assign md_stall_cnt = r_md_cnt;
  assign flush_cnt    = r_fl_cnt;
  assign dbg_state    = r_state;

endmodule
